display_scheduler: RTL and testbench

- Sequencer/arbiter in front of the 7-segment converter.
- Shares the single display between two requesters: a numeric source (0-255) and a letter source (5-bit code).
- Drives the converter's select, numero and letra inputs.
- Each accepted request owns the display for a guaranteed minimum dwell time before another can take it.

---
 rtl/display_scheduler.sv | 178 +++++++++++++++++
 tb/tb_display_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates a numeric source and a letter source onto a
// single 7-segment converter, holding each grant for DWELL cycles.
// Optional: define DISPLAY_SCHEDULER_ALT_EN to auto-alternate between the two
// captured values while idle once both sources have been shown.
module display_scheduler #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned DW    = 10
) (
  input  logic       clock,
  input  logic       zera_s,
  input  logic       req_num,
  input  logic [7:0] num_in,
  input  logic       req_letra,
  input  logic [4:0] letra_in,
  output logic       ack_num,
  output logic       ack_letra,
  output logic       select,
  output logic [7:0] numero,
  output logic [4:0] letra,
  output logic       busy
);

  localparam logic [DW-1:0] CNT_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHOW_NUM   = 2'd1,
    SHOW_LETRA = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_NUM   = 1'b0,
    GRANT_LETRA = 1'b1
  } grant_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  grant_t        last_grant_q, last_grant_d;
  logic          ack_num_q, ack_num_d;
  logic          ack_letra_q, ack_letra_d;
  logic          select_q, select_d;
  logic [7:0]    numero_q, numero_d;
  logic [4:0]    letra_q, letra_d;
  logic          busy_q, busy_d;
`ifdef DISPLAY_SCHEDULER_ALT_EN
  logic          valid_num_q, valid_num_d;
  logic          valid_letra_q, valid_letra_d;
`endif

  logic any_req;
  logic at_last;
  logic grant_num;
  logic take;

  // Sampling point and round-robin winner (numeric wins unless it won last time)
  always_comb begin
    any_req   = req_num | req_letra;
    at_last   = (cnt_q == CNT_LAST);
    grant_num = req_num & (~req_letra | (last_grant_q == GRANT_LETRA));
    take      = any_req & ((state_q == IDLE) | at_last);
  end

  // Next-state and registered-output logic; a grant overrides the hold paths
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ack_num_d    = 1'b0;
    ack_letra_d  = 1'b0;
    select_d     = select_q;
    numero_d     = numero_q;
    letra_d      = letra_q;
    busy_d       = busy_q;
`ifdef DISPLAY_SCHEDULER_ALT_EN
    valid_num_d   = valid_num_q;
    valid_letra_d = valid_letra_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
`ifdef DISPLAY_SCHEDULER_ALT_EN
        if (valid_num_q && valid_letra_q) begin
          if (at_last) begin
            select_d = ~select_q;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end else begin
          cnt_d = '0;
        end
`else
        cnt_d = '0;
`endif
      end
      SHOW_NUM, SHOW_LETRA: begin
        if (at_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    if (take) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      if (grant_num) begin
        state_d      = SHOW_NUM;
        last_grant_d = GRANT_NUM;
        ack_num_d    = 1'b1;
        numero_d     = num_in;
        select_d     = 1'b0;
`ifdef DISPLAY_SCHEDULER_ALT_EN
        valid_num_d  = 1'b1;
`endif
      end else begin
        state_d       = SHOW_LETRA;
        last_grant_d  = GRANT_LETRA;
        ack_letra_d   = 1'b1;
        letra_d       = letra_in;
        select_d      = 1'b1;
`ifdef DISPLAY_SCHEDULER_ALT_EN
        valid_letra_d = 1'b1;
`endif
      end
    end
  end

  // State and output registers; synchronous reset takes priority over everything
  always_ff @(posedge clock) begin
    if (zera_s) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_LETRA;
      ack_num_q    <= 1'b0;
      ack_letra_q  <= 1'b0;
      select_q     <= 1'b0;
      numero_q     <= '0;
      letra_q      <= '0;
      busy_q       <= 1'b0;
`ifdef DISPLAY_SCHEDULER_ALT_EN
      valid_num_q   <= 1'b0;
      valid_letra_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ack_num_q    <= ack_num_d;
      ack_letra_q  <= ack_letra_d;
      select_q     <= select_d;
      numero_q     <= numero_d;
      letra_q      <= letra_d;
      busy_q       <= busy_d;
`ifdef DISPLAY_SCHEDULER_ALT_EN
      valid_num_q   <= valid_num_d;
      valid_letra_q <= valid_letra_d;
`endif
    end
  end

  assign ack_num   = ack_num_q;
  assign ack_letra = ack_letra_q;
  assign select    = select_q;
  assign numero    = numero_q;
  assign letra     = letra_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with DWELL=4, DW=3.
module tb_display_scheduler;

  localparam int unsigned DWELL = 4;
  localparam int unsigned DW    = 3;

  logic       clock = 1'b0;
  logic       zera_s;
  logic       req_num;
  logic [7:0] num_in;
  logic       req_letra;
  logic [4:0] letra_in;
  logic       ack_num;
  logic       ack_letra;
  logic       select;
  logic [7:0] numero;
  logic [4:0] letra;
  logic       busy;

  display_scheduler #(.DWELL(DWELL), .DW(DW)) dut (
    .clock     (clock),
    .zera_s    (zera_s),
    .req_num   (req_num),
    .num_in    (num_in),
    .req_letra (req_letra),
    .letra_in  (letra_in),
    .ack_num   (ack_num),
    .ack_letra (ack_letra),
    .select    (select),
    .numero    (numero),
    .letra     (letra),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Count of rising edges; stable when sampled on the falling edge
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         cyc;
    bit         is_letra;
    logic [7:0] numero;
    logic [4:0] letra;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] m_num;
  logic [4:0] m_let;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_num = 8'd0;
    m_let = 5'd0;
  endtask

  task automatic push_num(input int c, input logic [7:0] v);
    m_num = v;
    sb_q.push_back('{c, 1'b0, m_num, m_let});
  endtask

  task automatic push_let(input int c, input logic [4:0] v);
    m_let = v;
    sb_q.push_back('{c, 1'b1, m_num, m_let});
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 32'({ack_num, ack_letra, select, busy, numero, letra}), 32'd0);
  endtask

  task automatic wait_ack(input bit is_letra, input int bound, input string name);
    int k = 0;
    while (!((is_letra ? ack_letra : ack_num) === 1'b1)) begin
      if (k >= bound) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s: ack not seen within %0d cycles", name, bound);
        return;
      end
      tick();
      k++;
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int k = 0;
    while (busy !== 1'b0) begin
      if (k >= bound) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s: busy did not drop within %0d cycles", name, bound);
        return;
      end
      tick();
      k++;
    end
  endtask

  // Monitor: every ack must match the next expected grant, including its cycle
  always @(negedge clock) begin
    if (ack_num === 1'b1 || ack_letra === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: ack_num=%b ack_letra=%b at cycle %0d, none expected",
                 ack_num, ack_letra, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (cyc !== mon_e.cyc || ack_letra !== mon_e.is_letra || ack_num !== !mon_e.is_letra ||
            select !== mon_e.is_letra || numero !== mon_e.numero || letra !== mon_e.letra ||
            busy !== 1'b1) begin
          n_fail++;
          $display("FAIL grant: got cyc=%0d an=%b al=%b sel=%b num=%0d let=%0d busy=%b expected cyc=%0d an=%b al=%b sel=%b num=%0d let=%0d busy=1",
                   cyc, ack_num, ack_letra, select, numero, letra, busy,
                   mon_e.cyc, !mon_e.is_letra, mon_e.is_letra, mon_e.is_letra,
                   mon_e.numero, mon_e.letra);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic exp_sel;

    // Reset held two cycles with both requests pending
    zera_s    = 1'b1;
    req_num   = 1'b1;
    num_in    = 8'd77;
    req_letra = 1'b1;
    letra_in  = 5'd9;
    model_reset();
    tick();
    check_reset_outputs("reset_hold_1");
    tick();
    check_reset_outputs("reset_hold_2");
    zera_s = 1'b0;
    c = cyc;
    push_num(c + 1, 8'd77);
    push_let(c + 5, 5'd9);
    wait_ack(1'b0, 4, "s1_ack_num");
    req_num = 1'b0;
    wait_ack(1'b1, 8, "s1_ack_letra");
    req_letra = 1'b0;
    repeat (3) tick();
    check("s1_busy_tail", 32'(busy), 32'd1);
    tick();
    check("s1_busy_drop", 32'(busy), 32'd0);

    // Single numeric request from idle; busy lasts exactly DWELL cycles
    num_in  = 8'd123;
    req_num = 1'b1;
    c = cyc;
    push_num(c + 1, 8'd123);
    wait_ack(1'b0, 4, "s2_ack_num");
    req_num = 1'b0;
    check("s2_busy_0", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("s2_busy_dwell", 32'(busy), 32'd1);
    end
    tick();
    check("s2_busy_end", 32'(busy), 32'd0);
    check("s2_numero_hold", 32'(numero), 32'd123);
    check("s2_select_hold", 32'(select), 32'd0);

    // Reset, then both request together: numeric first, letter after one dwell
    zera_s    = 1'b1;
    num_in    = 8'd45;
    letra_in  = 5'd3;
    req_num   = 1'b1;
    req_letra = 1'b1;
    tick();
    check_reset_outputs("s3_reset");
    model_reset();
    zera_s = 1'b0;
    c = cyc;
    push_num(c + 1, 8'd45);
    push_let(c + 5, 5'd3);
    wait_ack(1'b0, 4, "s3_ack_num");
    req_num = 1'b0;
    wait_ack(1'b1, 8, "s3_ack_letra");
    req_letra = 1'b0;
    check("s3_numero_kept", 32'(numero), 32'd45);
    wait_idle(8, "s3_idle");

    // Letter request raised mid-dwell is served back-to-back at the dwell end
    num_in  = 8'd200;
    req_num = 1'b1;
    c = cyc;
    push_num(c + 1, 8'd200);
    wait_ack(1'b0, 4, "s4_ack_num");
    req_num = 1'b0;
    tick();
    letra_in  = 5'd17;
    req_letra = 1'b1;
    push_let(c + 5, 5'd17);
    wait_ack(1'b1, 6, "s4_ack_letra");
    req_letra = 1'b0;
    wait_idle(8, "s4_idle");

    // Numeric request held past its ack: one re-grant at the next sampling point
    num_in  = 8'd66;
    req_num = 1'b1;
    c = cyc;
    push_num(c + 1, 8'd66);
    push_num(c + 5, 8'd66);
    wait_ack(1'b0, 4, "s5_ack_first");
    tick();
    wait_ack(1'b0, 6, "s5_ack_second");
    req_num = 1'b0;
    wait_idle(8, "s5_idle");

    // Reset in the middle of a letter dwell with a numeric request held
    letra_in  = 5'd21;
    req_letra = 1'b1;
    c = cyc;
    push_let(c + 1, 5'd21);
    wait_ack(1'b1, 4, "s6_ack_letra");
    req_letra = 1'b0;
    repeat (2) tick();
    zera_s  = 1'b1;
    num_in  = 8'd99;
    req_num = 1'b1;
    tick();
    check_reset_outputs("s6_reset_mid");
    model_reset();
    zera_s = 1'b0;
    push_num(cyc + 1, 8'd99);
    wait_ack(1'b0, 4, "s6_ack_num");
    req_num = 1'b0;
    wait_idle(8, "s6_idle");

    // Show the letter too, then watch select while idle
    letra_in  = 5'd5;
    req_letra = 1'b1;
    push_let(cyc + 1, 5'd5);
    wait_ack(1'b1, 4, "s7_ack_letra");
    req_letra = 1'b0;
    wait_idle(8, "s7_idle");
    for (int k = 0; k < 12; k++) begin
`ifdef DISPLAY_SCHEDULER_ALT_EN
      exp_sel = ((k / 4) % 2 == 1) ? 1'b0 : 1'b1;
`else
      exp_sel = 1'b1;
`endif
      check("s7_idle_select", 32'(select), 32'(exp_sel));
      check("s7_idle_busy", 32'(busy), 32'd0);
      tick();
    end
    check("s7_numero_kept", 32'(numero), 32'd99);
    check("s7_letra_kept", 32'(letra), 32'd5);

    tick();
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
